// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end with sub-word RMW, load extension and access error checks
// Optional: define MAU_STATS_EN to add saturating load/store/error response counters.
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_out
`ifdef MAU_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_req_err;
  logic [15:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_data;
  logic [31:0] w_merged;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_req_err = (req_size == 2'd3)
                   || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && (req_addr[1:0] != 2'b00))
                   || (req_addr >= ADDR_LIMIT);

  // Selected lane is shifted down to bit 0; halfwords only ever shift by 0 or 16.
  assign w_lane = 16'(mem_out >> {r_addr[1:0], 3'b000});

  always_comb begin
    w_load = mem_out;
    case (r_size)
      2'd0:    w_load = r_unsigned ? {24'h0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      2'd1:    w_load = r_unsigned ? {16'h0, w_lane} : {{16{w_lane[15]}}, w_lane};
      default: w_load = mem_out;
    endcase
  end

  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_data = r_wdata;
    case (r_size)
      2'd0: begin
        w_mask = 32'h0000_00FF << {r_addr[1:0], 3'b000};
        w_data = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_mask = 32'h0000_FFFF << {r_addr[1], 4'b0000};
        w_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_data = r_wdata;
      end
    endcase
  end

  assign w_merged = (r_word & ~w_mask) | (w_data & w_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_word     <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_write    <= req_write;
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
          r_addr     <= req_addr;
          r_wdata    <= req_wdata;
          r_word     <= 32'h0;
          r_rdata    <= 32'h0;
          r_err      <= w_req_err;
          if (w_req_err)                          r_state <= S_RESP;
          else if (req_write && req_size == 2'd2) r_state <= S_WRITE;
          else                                    r_state <= S_READ;
        end
        S_READ: begin
          r_word <= mem_out;
          if (r_write) begin
            r_state <= S_WRITE;
          end else begin
            r_rdata <= w_load;
            r_state <= S_RESP;
          end
        end
        S_WRITE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_err     = rsp_valid && r_err;
  assign rsp_rdata   = r_rdata;
  assign mem_read    = (r_state == S_READ);
  assign mem_write   = (r_state == S_WRITE);
  assign mem_address = {r_addr[31:2], 2'b00};
  assign mem_in      = w_merged;

`ifdef MAU_STATS_EN
  logic [15:0] r_stat_loads;
  logic [15:0] r_stat_stores;
  logic [15:0] r_stat_errs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_loads  <= 16'h0;
      r_stat_stores <= 16'h0;
      r_stat_errs   <= 16'h0;
    end else if (r_state == S_RESP) begin
      if (r_err) begin
        if (r_stat_errs != 16'hFFFF) r_stat_errs <= r_stat_errs + 16'd1;
      end else if (r_write) begin
        if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
      end else begin
        if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
      end
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a behavioural word memory
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_out;
`ifdef MAU_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errs;
`endif

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_address(mem_address), .mem_in(mem_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_out(mem_out)
`ifdef MAU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  logic [31:0] mem [0:255];
  assign mem_out = mem_read ? mem[mem_address[9:2]] : 32'h0;
  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_in;

  int n_tests = 0;
  int n_fail  = 0;

  int          o_lat, o_vcnt, o_rcnt, o_wcnt, o_both;
  logic        o_acc, o_err;
  logic [31:0] o_rdata, o_waddr, o_wdata;

  task automatic preload();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h12345678;
    mem[6] = 32'h89abcdef;
  endtask

  task automatic observe();
    if (rsp_valid) begin
      o_vcnt++;
      if (o_lat == 0) begin
        o_lat = 0; o_rdata = rsp_rdata; o_err = rsp_err;
      end
    end
    if (mem_read) o_rcnt++;
    if (mem_write) begin
      o_wcnt++; o_waddr = mem_address; o_wdata = mem_in;
    end
    if (mem_read && mem_write) o_both++;
  endtask

  // Entered at #1 after a rising edge; returns at #1 after the fifth edge following acceptance.
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    o_lat = 0; o_vcnt = 0; o_rcnt = 0; o_wcnt = 0; o_both = 0;
    o_acc = 1'b0; o_err = 1'b0; o_rdata = 32'hDEAD_BEEF; o_waddr = 32'h0; o_wdata = 32'h0;
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 10 && !o_acc; i++) begin
      if (req_ready) o_acc = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_write = ~wr; req_size = 2'd3; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    for (int k = 1; k <= 5; k++) begin
      if (rsp_valid && o_lat == 0) begin
        o_lat = k; o_rdata = rsp_rdata; o_err = rsp_err;
      end
      if (rsp_valid) o_vcnt++;
      if (mem_read) o_rcnt++;
      if (mem_write) begin o_wcnt++; o_waddr = mem_address; o_wdata = mem_in; end
      if (mem_read && mem_write) o_both++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (!o_acc) begin n_fail++; $display("FAIL accept: request not accepted within 10 cycles"); end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 10000",
                         {req_ready, rsp_valid, rsp_err, mem_read, mem_write});
    end
    n_tests++;
    if ({rsp_rdata, mem_address, mem_in} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h addr=%h in=%h expected all 0",
                         rsp_rdata, mem_address, mem_in);
    end
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, mem_read, mem_write} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_release: got %b expected 1000",
                         {req_ready, rsp_valid, mem_read, mem_write});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    do_access(1'b0, 2'd2, 1'b0, 32'd16, 32'h0);
    n_tests++;
    if (o_rdata !== 32'h12345678 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL word_load: rdata=%h err=%b expected 12345678 err=0", o_rdata, o_err);
    end
    n_tests++;
    if (o_lat !== 2 || o_vcnt !== 1 || o_rcnt !== 1 || o_wcnt !== 0) begin
      n_fail++; $display("FAIL word_load_timing: lat=%0d valid=%0d rd=%0d wr=%0d expected 2 1 1 0",
                         o_lat, o_vcnt, o_rcnt, o_wcnt);
    end
  endtask

  task automatic test_subword_load();
    do_access(1'b0, 2'd0, 1'b0, 32'd25, 32'h0);
    n_tests++;
    if (o_rdata !== 32'hFFFFFFCD || o_err !== 1'b0 || o_lat !== 2) begin
      n_fail++; $display("FAIL byte_load_signed: rdata=%h err=%b lat=%0d expected FFFFFFCD 0 2",
                         o_rdata, o_err, o_lat);
    end
    do_access(1'b0, 2'd0, 1'b1, 32'd25, 32'h0);
    n_tests++;
    if (o_rdata !== 32'h000000CD || o_err !== 1'b0) begin
      n_fail++; $display("FAIL byte_load_unsigned: rdata=%h err=%b expected 000000CD 0", o_rdata, o_err);
    end
    do_access(1'b0, 2'd1, 1'b1, 32'd18, 32'h0);
    n_tests++;
    if (o_rdata !== 32'h00001234 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL half_load_unsigned: rdata=%h err=%b expected 00001234 0", o_rdata, o_err);
    end
    do_access(1'b0, 2'd1, 1'b0, 32'd26, 32'h0);
    n_tests++;
    if (o_rdata !== 32'hFFFF89AB || o_err !== 1'b0) begin
      n_fail++; $display("FAIL half_load_signed: rdata=%h err=%b expected FFFF89AB 0", o_rdata, o_err);
    end
  endtask

  task automatic test_byte_store();
    do_access(1'b1, 2'd0, 1'b0, 32'd17, 32'h000000AA);
    n_tests++;
    if (o_rcnt !== 1 || o_wcnt !== 1 || o_waddr !== 32'd16 || o_wdata !== 32'h1234AA78) begin
      n_fail++; $display("FAIL byte_store_mem: rd=%0d wr=%0d addr=%h in=%h expected 1 1 00000010 1234AA78",
                         o_rcnt, o_wcnt, o_waddr, o_wdata);
    end
    n_tests++;
    if (o_lat !== 3 || o_vcnt !== 1 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      n_fail++; $display("FAIL byte_store_rsp: lat=%0d valid=%0d err=%b rdata=%h expected 3 1 0 0",
                         o_lat, o_vcnt, o_err, o_rdata);
    end
    do_access(1'b0, 2'd2, 1'b0, 32'd16, 32'h0);
    n_tests++;
    if (o_rdata !== 32'h1234AA78) begin
      n_fail++; $display("FAIL byte_store_reload: rdata=%h expected 1234AA78", o_rdata);
    end
    do_access(1'b1, 2'd1, 1'b0, 32'd18, 32'h0000BEEF);
    n_tests++;
    if (o_wcnt !== 1 || o_wdata !== 32'hBEEFAA78 || o_lat !== 3) begin
      n_fail++; $display("FAIL half_store: wr=%0d in=%h lat=%0d expected 1 BEEFAA78 3",
                         o_wcnt, o_wdata, o_lat);
    end
  endtask

  task automatic test_errors();
    logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] ad [4] = '{32'd19, 32'd26, 32'd16, 32'd1024};
    for (int i = 0; i < 4; i++) begin
      do_access(i[0], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
      n_tests++;
      if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_lat !== 1 || o_vcnt !== 1
          || o_rcnt !== 0 || o_wcnt !== 0) begin
        n_fail++; $display("FAIL error_%0d: err=%b rdata=%h lat=%0d valid=%0d rd=%0d wr=%0d expected 1 0 1 1 0 0",
                           i, o_err, o_rdata, o_lat, o_vcnt, o_rcnt, o_wcnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 2'd2, 1'b0, 32'd24, 32'hCAFEF00D);
    n_tests++;
    if (o_lat !== 2 || o_rcnt !== 0 || o_wcnt !== 1 || o_waddr !== 32'd24 || o_wdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL word_store: lat=%0d rd=%0d wr=%0d addr=%h in=%h expected 2 0 1 00000018 CAFEF00D",
                         o_lat, o_rcnt, o_wcnt, o_waddr, o_wdata);
    end
    do_access(1'b0, 2'd2, 1'b0, 32'd24, 32'h0);
    n_tests++;
    if (o_rdata !== 32'hCAFEF00D || o_both !== 0) begin
      n_fail++; $display("FAIL word_store_reload: rdata=%h both=%0d expected CAFEF00D 0", o_rdata, o_both);
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen = 0;
    int v_seen = 0;
    req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'd26; req_wdata = 32'h00001111;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++;
    if (mem_read !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_read: mem_read=%b expected 1", mem_read);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, mem_read, mem_write, rsp_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_mid_abort: got %b expected 1000",
                         {req_ready, mem_read, mem_write, rsp_valid});
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin @(negedge clk); rst_n = 1'b1; end
      @(posedge clk); #1;
      if (mem_write) wr_seen++;
      if (rsp_valid) v_seen++;
    end
    n_tests++;
    if (wr_seen !== 0 || v_seen !== 0) begin
      n_fail++; $display("FAIL reset_mid_quiet: writes=%0d rsp=%0d expected 0 0", wr_seen, v_seen);
    end
    do_access(1'b0, 2'd2, 1'b0, 32'd24, 32'h0);
    n_tests++;
    if (o_rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL reset_mid_reload: rdata=%h expected CAFEF00D", o_rdata);
    end
  endtask

`ifdef MAU_STATS_EN
  task automatic test_stats();
    preload();
    apply_reset();
    n_tests++;
    if ({stat_loads, stat_stores, stat_errs} !== 48'h0) begin
      n_fail++; $display("FAIL stats_reset: %h %h %h expected 0 0 0", stat_loads, stat_stores, stat_errs);
    end
    do_access(1'b0, 2'd2, 1'b0, 32'd16, 32'h0);
    do_access(1'b0, 2'd0, 1'b0, 32'd25, 32'h0);
    do_access(1'b0, 2'd0, 1'b1, 32'd25, 32'h0);
    do_access(1'b0, 2'd1, 1'b1, 32'd18, 32'h0);
    do_access(1'b1, 2'd0, 1'b0, 32'd17, 32'h000000AA);
    do_access(1'b0, 2'd1, 1'b0, 32'd19, 32'h0);
    do_access(1'b0, 2'd2, 1'b0, 32'd26, 32'h0);
    do_access(1'b0, 2'd3, 1'b0, 32'd16, 32'h0);
    do_access(1'b0, 2'd2, 1'b0, 32'd1024, 32'h0);
    n_tests++;
    if (stat_loads !== 16'd4 || stat_stores !== 16'd1 || stat_errs !== 16'd4) begin
      n_fail++; $display("FAIL stats_counts: loads=%0d stores=%0d errs=%0d expected 4 1 4",
                         stat_loads, stat_stores, stat_errs);
    end
  endtask
`endif

  initial begin
    preload();
    test_reset();
    test_word_load();
    test_subword_load();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef MAU_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
